// File: rtl/spike_scanner_pkg.sv
// Shared types and sizing for the spike scanner: neuron/lane geometry, the signed
// charge type, the scan FSM encoding and a lane-extraction helper.
package snn_pkg;

   localparam int N_NEURONS = 256;
   localparam int LANES     = 4;
   localparam int CHARGE_W  = 8;
   localparam int GROUPS    = 64;
   localparam int GRP_W     = $clog2(GROUPS);
   localparam int LANE_W    = $clog2(LANES);
   localparam int ADDR_W    = $clog2(N_NEURONS);
   localparam int CNT_W     = ADDR_W + 1;
   localparam int WORD_W    = LANES * CHARGE_W;

   typedef logic signed [CHARGE_W-1:0] charge_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EMIT  = 2'd2,
      DONE  = 2'd3
   } scan_state_e;

   // Lane 0 sits in the least significant byte of the read word.
   function automatic charge_t lane_charge(input logic [WORD_W-1:0] word, input int lane);
      return charge_t'(word[lane*CHARGE_W +: CHARGE_W]);
   endfunction

endpackage

// File: rtl/spike_scanner_lane_pick.sv
// Priority picker: returns the lowest-numbered pending lane and whether any lane is pending.
module spike_lane_pick
   import snn_pkg::*;
(
   input  logic [LANES-1:0]  pend_i,
   output logic [LANE_W-1:0] lane_o,
   output logic              any_o
);

   // Walk from the top lane down so the lowest set lane wins.
   always_comb begin
      lane_o = LANE_W'(0);
      any_o  = |pend_i;
      for (int l = LANES - 1; l >= 0; l--) begin
         lane_o = pend_i[l] ? LANE_W'(l) : lane_o;
      end
   end

endmodule

// File: rtl/spike_scanner.sv
// Scans all neuron charges group by group and emits one AER event per newly firing neuron.
// Optional feature: define SPIKE_SCANNER_COUNT_EN to add the per-scan spike_count_o counter.
module spike_scanner
   import snn_pkg::*;
(
   input  logic                CLK,
   input  logic                RSTN,
   input  logic                scan_start_i,
   input  logic [CHARGE_W-1:0] threshold_i,
   input  logic                fired_clear_i,
   output logic [GRP_W-1:0]    count_o,
   input  logic [WORD_W-1:0]   synapse_charge_i,
   output logic                aer_valid_o,
   input  logic                aer_ready_i,
   output logic [ADDR_W-1:0]   aer_addr_o,
   output logic                scan_busy_o,
   output logic                scan_done_o
`ifdef SPIKE_SCANNER_COUNT_EN
   ,
   output logic [CNT_W-1:0]    spike_count_o
`endif
);

   scan_state_e            state_q;
   logic [GRP_W-1:0]       grp_q;
   charge_t                threshold_q;
   logic [N_NEURONS-1:0]   fired_q;
   logic [LANES-1:0]       pend_q;
   logic [LANES-1:0]       pend_d;
   logic                   valid_q;
   logic [ADDR_W-1:0]      addr_q;
   logic                   busy_q;
   logic                   done_q;
   logic [LANES-1:0]       fired_grp;
   logic [LANE_W-1:0]      lane_d;
   logic                   any_d;
   logic                   handshake;

   assign count_o     = grp_q;
   assign aer_valid_o = valid_q;
   assign aer_addr_o  = addr_q;
   assign scan_busy_o = busy_q;
   assign scan_done_o = done_q;

   // Next pending-lane set: built from the read word in FETCH, retired one lane per handshake in EMIT.
   always_comb begin
      handshake = valid_q && aer_ready_i;
      fired_grp = fired_q[{grp_q, LANE_W'(0)} +: LANES];
      pend_d    = pend_q;
      case (state_q)
         FETCH: begin
            for (int l = 0; l < LANES; l++) begin
               pend_d[l] = (lane_charge(synapse_charge_i, l) >= threshold_q) && !fired_grp[l];
            end
         end
         EMIT: begin
            if (handshake) begin
               pend_d = pend_q & ~(LANES'(1) << addr_q[LANE_W-1:0]);
            end else begin
               pend_d = pend_q;
            end
         end
         default: pend_d = '0;
      endcase
   end

   spike_lane_pick u_pick (
      .pend_i (pend_d),
      .lane_o (lane_d),
      .any_o  (any_d)
   );

   // Scan FSM with registered AER, busy and done outputs.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q     <= IDLE;
         grp_q       <= '0;
         threshold_q <= '0;
         fired_q     <= '0;
         pend_q      <= '0;
         valid_q     <= 1'b0;
         addr_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               // A clear arriving with start lands before the first FETCH reads the bitmap.
               if (fired_clear_i) begin
                  fired_q <= '0;
               end
               if (scan_start_i) begin
                  state_q     <= FETCH;
                  grp_q       <= '0;
                  threshold_q <= charge_t'(threshold_i);
                  busy_q      <= 1'b1;
               end
            end
            FETCH: begin
               pend_q  <= pend_d;
               valid_q <= any_d;
               addr_q  <= {grp_q, lane_d};
               state_q <= EMIT;
            end
            EMIT: begin
               if (pend_q == '0) begin
                  valid_q <= 1'b0;
                  if (grp_q == GRP_W'(GROUPS - 1)) begin
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     grp_q   <= grp_q + GRP_W'(1);
                     state_q <= FETCH;
                  end
               end else begin
                  if (handshake) begin
                     fired_q[addr_q] <= 1'b1;
                  end
                  pend_q  <= pend_d;
                  valid_q <= any_d;
                  addr_q  <= {grp_q, lane_d};
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
               if (fired_clear_i) begin
                  fired_q <= '0;
               end
            end
            default: begin
               state_q <= IDLE;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

`ifdef SPIKE_SCANNER_COUNT_EN
   logic [CNT_W-1:0] spike_count_q;

   assign spike_count_o = spike_count_q;

   // Per-scan event counter; saturates at the neuron count and holds until the next start.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         spike_count_q <= '0;
      end else if (state_q == IDLE && scan_start_i) begin
         spike_count_q <= '0;
      end else if (state_q == EMIT && handshake && spike_count_q != CNT_W'(N_NEURONS)) begin
         spike_count_q <= spike_count_q + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_spike_scanner.sv
// Scoreboard bench for spike_scanner: stimulus pushes expected AER addresses, a monitor pops on handshakes.
module tb_spike_scanner;

   logic        CLK = 1'b0;
   logic        RSTN = 1'b0;
   logic        scan_start_i = 1'b0;
   logic [7:0]  threshold_i = 8'd0;
   logic        fired_clear_i = 1'b0;
   logic [5:0]  count_o;
   logic [31:0] synapse_charge_i;
   logic        aer_valid_o;
   logic        aer_ready_i = 1'b1;
   logic [7:0]  aer_addr_o;
   logic        scan_busy_o;
   logic        scan_done_o;
`ifdef SPIKE_SCANNER_COUNT_EN
   logic [8:0]  spike_count_o;
`endif

   logic [31:0] mem [64];
   int          checks = 0;
   int          errors = 0;
   int          busy_cycles = 0;
   int          done_pulses = 0;
   int          events = 0;
   bit          prev_busy = 1'b0;
   int          sb [$];

   assign synapse_charge_i = mem[count_o];

   always #5 CLK = ~CLK;

   spike_scanner dut (
      .CLK              (CLK),
      .RSTN             (RSTN),
      .scan_start_i     (scan_start_i),
      .threshold_i      (threshold_i),
      .fired_clear_i    (fired_clear_i),
      .count_o          (count_o),
      .synapse_charge_i (synapse_charge_i),
      .aer_valid_o      (aer_valid_o),
      .aer_ready_i      (aer_ready_i),
      .aer_addr_o       (aer_addr_o),
      .scan_busy_o      (scan_busy_o),
      .scan_done_o      (scan_done_o)
`ifdef SPIKE_SCANNER_COUNT_EN
      ,
      .spike_count_o    (spike_count_o)
`endif
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic fill(input logic [31:0] v);
      for (int g = 0; g < 64; g++) mem[g] = v;
   endtask

   task automatic push_grp5();
      sb.push_back(20);
      sb.push_back(21);
      sb.push_back(23);
   endtask

   // Monitor: busy/done accounting and scoreboard pops on every accepted event.
   initial begin
      forever begin
         @(negedge CLK);
         if (RSTN) begin
            if (scan_busy_o) busy_cycles++;
            if (scan_done_o) begin
               done_pulses++;
               chk("done_after_busy", int'(prev_busy && !scan_busy_o), 1);
            end
            if (aer_valid_o && aer_ready_i) begin
               events++;
               if (sb.size() == 0) begin
                  chk("unexpected_event", int'(aer_addr_o), -1);
               end else begin
                  chk("aer_addr", int'(aer_addr_o), sb.pop_front());
               end
            end
            prev_busy = scan_busy_o;
         end
      end
   end

   task automatic run_scan(input logic [7:0] thr, input bit clr, input int exp_busy,
                           input bit stall, input bit poke);
      bit seen;
      busy_cycles = 0;
      done_pulses = 0;
      events      = 0;
      @(posedge CLK); #1;
      if (stall) aer_ready_i = 1'b0;
      scan_start_i  = 1'b1;
      threshold_i   = thr;
      fired_clear_i = clr;
      @(posedge CLK); #1;
      scan_start_i  = 1'b0;
      fired_clear_i = 1'b0;
      threshold_i   = 8'd127;
      if (poke) begin
         repeat (20) @(posedge CLK);
         #1 scan_start_i = 1'b1;
         @(posedge CLK); #1 scan_start_i = 1'b0;
      end
      if (stall) begin
         seen = 1'b0;
         for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge CLK);
            seen = aer_valid_o;
         end
         chk("stall_valid_seen", int'(seen), 1);
         for (int i = 0; i < 10; i++) begin
            chk("stall_valid", int'(aer_valid_o), 1);
            chk("stall_addr", int'(aer_addr_o), 20);
            chk("stall_count", int'(count_o), 5);
            @(negedge CLK);
         end
         @(posedge CLK); #1 aer_ready_i = 1'b1;
      end
      seen = 1'b0;
      for (int i = 0; i < 3000 && !seen; i++) begin
         @(negedge CLK);
         seen = scan_done_o;
      end
      chk("done_seen", int'(seen), 1);
      repeat (3) @(negedge CLK);
      chk("done_pulses", done_pulses, 1);
      if (exp_busy >= 0) chk("busy_cycles", busy_cycles, exp_busy);
      chk("sb_empty", sb.size(), 0);
      aer_ready_i = 1'b1;
   endtask

   initial begin
      bit seen;
      fill(32'h0);
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("rst_valid", int'(aer_valid_o), 0);
      chk("rst_busy", int'(scan_busy_o), 0);
      chk("rst_done", int'(scan_done_o), 0);
      chk("rst_count", int'(count_o), 0);
      chk("rst_addr", int'(aer_addr_o), 0);
      @(posedge CLK); #1 RSTN = 1'b1;

      // All-zero charges, thr=1, with a start poke mid-scan that must be ignored.
      run_scan(8'd1, 1'b0, 128, 1'b0, 1'b1);

      // Group 5 = {10,-3,1,1}: events 20,21,23.
      mem[5] = 32'h0AFD0101;
      push_grp5();
      run_scan(8'd1, 1'b0, 131, 1'b0, 1'b0);
`ifdef SPIKE_SCANNER_COUNT_EN
      chk("spike_count_g5", int'(spike_count_o), 3);
`endif

      // Rescan without clear: nothing fires.
      run_scan(8'd1, 1'b0, 128, 1'b0, 1'b0);

      // Clear in IDLE, then the same events return.
      @(posedge CLK); #1 fired_clear_i = 1'b1;
      @(posedge CLK); #1 fired_clear_i = 1'b0;
      push_grp5();
      run_scan(8'd1, 1'b0, 131, 1'b0, 1'b0);

      // Backpressure on address 20 (clear with start).
      push_grp5();
      run_scan(8'd1, 1'b1, -1, 1'b1, 1'b0);

      // thr=-128 fires every neuron, including a -128 charge.
      fill(32'h0);
      mem[10] = 32'h00000080;
      for (int i = 0; i < 256; i++) sb.push_back(i);
      run_scan(8'h80, 1'b1, 384, 1'b0, 1'b0);
`ifdef SPIKE_SCANNER_COUNT_EN
      chk("spike_count_all", int'(spike_count_o), 256);
`endif

      // charge 127 vs thr=-1 fires; the -128 background stays silent.
      fill(32'h80808080);
      mem[7] = 32'h807F8080;
      sb.push_back(30);
      run_scan(8'hFF, 1'b1, 129, 1'b0, 1'b0);

      // charge -1 vs thr=0 silent (addr 36); charge 0 fires (addr 37).
      fill(32'h80808080);
      mem[9] = 32'h808000FF;
      sb.push_back(37);
      run_scan(8'h00, 1'b1, 129, 1'b0, 1'b0);

      // Reset while an event is pending in EMIT.
      fill(32'h0);
      mem[5] = 32'h0AFD0101;
      @(posedge CLK); #1;
      aer_ready_i   = 1'b0;
      scan_start_i  = 1'b1;
      fired_clear_i = 1'b1;
      threshold_i   = 8'd1;
      @(posedge CLK); #1;
      scan_start_i  = 1'b0;
      fired_clear_i = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge CLK);
         seen = aer_valid_o;
      end
      chk("pre_reset_valid", int'(seen), 1);
      @(posedge CLK); #1 RSTN = 1'b0;
      #1;
      chk("mid_rst_valid", int'(aer_valid_o), 0);
      chk("mid_rst_busy", int'(scan_busy_o), 0);
      chk("mid_rst_count", int'(count_o), 0);
      chk("mid_rst_addr", int'(aer_addr_o), 0);
      repeat (2) @(posedge CLK);
      #1 RSTN = 1'b1;
      aer_ready_i = 1'b1;
      push_grp5();
      run_scan(8'd1, 1'b0, 131, 1'b0, 1'b0);
`ifdef SPIKE_SCANNER_COUNT_EN
      chk("spike_count_after_rst", int'(spike_count_o), 3);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
